mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_reg_rc.sv | 33 +++
 rtl/mem_access_unit.sv | 98 +++++++++
 tb/tb_mem_access_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access FSM states and word geometry.
package mem_access_unit_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_e;

  // Beat counter width; a single-lane unit still needs one bit to exist.
  function automatic int beatWidth(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Beat-level memory bus between the access unit (master) and memory (slave).
// Handshake: mem_req is valid; mem_ack is ready. A beat transfers on a cycle with both high;
// the master holds mem_we/mem_addr/mem_wdata stable until then, and read data is valid with mem_ack.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_reg_rc.sv
// Load-data lane registers; one 32-bit lane is written per acknowledged read beat.
module reg_rc #(
  parameter int LANES  = 4,
  parameter int BEAT_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [BEAT_W-1:0]     sel,
  input  logic [31:0]           d,
  output logic [32*LANES-1:0]   q
);

  logic [LANES-1:0] laneWe;

  always_comb begin
    laneWe = '0;
    for (int i = 0; i < LANES; i++) begin
      laneWe[i] = we && (sel == BEAT_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (laneWe[i]) q[32*i +: 32] <= d;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: splits scalar/vector loads and stores into 32-bit beats,
// stalling the pipeline until the last beat is acknowledged.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memtoregM,
  input  logic                memwriteM,
  input  logic                memdataM,
  input  logic [ADDR_W-1:0]   addrM,
  input  logic [32*LANES-1:0] wdataM,
  mem_access_unit_if.master   mem,
  output logic                stallM,
  output logic [32*LANES-1:0] rdataM,
  output mau_state_e          dbgState
);

  localparam int BEAT_W = beatWidth(LANES);

  mau_state_e        state, stateNext;
  logic [BEAT_W-1:0] beat, beatNext;
  logic [BEAT_W-1:0] lastBeat;
  logic              request;
  logic              isRead;
  logic              rdWe;

  assign request  = memtoregM | memwriteM;
  // A combined load+store request is treated purely as a store.
  assign isRead   = memtoregM & ~memwriteM;
  assign lastBeat = memdataM ? BEAT_W'(LANES - 1) : '0;
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= stateNext;
      beat  <= beatNext;
    end
  end

  always_comb begin
    stateNext     = state;
    beatNext      = beat;
    stallM        = 1'b0;
    rdWe          = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        // Held in reset, no access can start, so the pipeline is not stalled.
        if (request && !reset) begin
          stallM    = 1'b1;
          stateNext = ACCESS;
          beatNext  = '0;
        end
      end
      ACCESS: begin
        stallM        = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = memwriteM;
        mem.mem_addr  = addrM + ADDR_W'(beat) * ADDR_W'(WORD_BYTES);
        mem.mem_wdata = wdataM[32*beat +: 32];
        if (mem.mem_ack) begin
          rdWe = isRead;
          if (beat == lastBeat) stateNext = DONE;
          else                  beatNext  = beat + 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  reg_rc #(
    .LANES  (LANES),
    .BEAT_W (BEAT_W)
  ) u_reg_rc (
    .clk   (clk),
    .reset (reset),
    .we    (rdWe),
    .sel   (beat),
    .d     (mem.mem_rdata),
    .q     (rdataM)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scalar/vector loads and stores, wait states,
// address wrap, reset mid-access and the combined load+store request.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int LANES  = 4;
  localparam int ADDR_W = 32;

  logic                clk;
  logic                reset;
  logic                memtoregM;
  logic                memwriteM;
  logic                memdataM;
  logic [ADDR_W-1:0]   addrM;
  logic [32*LANES-1:0] wdataM;
  logic                stallM;
  logic [32*LANES-1:0] rdataM;
  mau_state_e          dbgState;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) memBus ();

  mem_access_unit #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memtoregM (memtoregM),
    .memwriteM (memwriteM),
    .memdataM  (memdataM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .mem       (memBus),
    .stallM    (stallM),
    .rdataM    (rdataM),
    .dbgState  (dbgState)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stallCnt;
  logic [31:0]  wrapAddr [4];
  logic [127:0] expRdata;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    memtoregM        = 1'b0;
    memwriteM        = 1'b0;
    memdataM         = 1'b0;
    addrM            = '0;
    wdataM           = '0;
    memBus.mem_ack   = 1'b0;
    memBus.mem_rdata = '0;
  endtask

  initial begin
    wrapAddr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    reset = 1'b1;
    idleInputs();
    cyc();
    cyc();

    // Reset state
    chk("rst_state", 128'(dbgState), 128'(IDLE));
    chk("rst_req",   128'(memBus.mem_req), 128'(0));
    chk("rst_we",    128'(memBus.mem_we), 128'(0));
    chk("rst_addr",  128'(memBus.mem_addr), 128'(0));
    chk("rst_wdata", 128'(memBus.mem_wdata), 128'(0));
    chk("rst_stall", 128'(stallM), 128'(0));
    chk("rst_rdata", rdataM, 128'(0));
    reset = 1'b0;
    cyc();
    chk("idle_nostall", 128'(stallM), 128'(0));

    // Scalar load at 0x100
    memtoregM = 1'b1; addrM = 32'h100;
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("sl_idle_stall", 128'(stallM), 128'(1));
    chk("sl_idle_req",   128'(memBus.mem_req), 128'(0));
    cyc();
    chk("sl_state", 128'(dbgState), 128'(ACCESS));
    chk("sl_req",   128'(memBus.mem_req), 128'(1));
    chk("sl_we",    128'(memBus.mem_we), 128'(0));
    chk("sl_addr",  128'(memBus.mem_addr), 128'(32'h100));
    chk("sl_stall", 128'(stallM), 128'(1));
    cyc();
    chk("sl_done",       128'(dbgState), 128'(DONE));
    chk("sl_done_stall", 128'(stallM), 128'(0));
    chk("sl_done_req",   128'(memBus.mem_req), 128'(0));
    chk("sl_rdata",      rdataM, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    // Request still present in DONE must not start a new access
    cyc();
    chk("sl_done_to_idle", 128'(dbgState), 128'(IDLE));
    idleInputs();
    #1;
    chk("sl_idle_nostall", 128'(stallM), 128'(0));
    cyc();

    // Vector store at 0x200, lanes {4,3,2,1}
    memwriteM = 1'b1; memdataM = 1'b1; addrM = 32'h200;
    wdataM = {32'd4, 32'd3, 32'd2, 32'd1};
    memBus.mem_ack = 1'b1;
    cyc();
    for (int b = 0; b < 4; b++) begin
      chk("vs_req",   128'(memBus.mem_req), 128'(1));
      chk("vs_we",    128'(memBus.mem_we), 128'(1));
      chk("vs_addr",  128'(memBus.mem_addr), 128'(32'h200 + 4 * b));
      chk("vs_wdata", 128'(memBus.mem_wdata), 128'(b + 1));
      cyc();
    end
    chk("vs_done",  128'(dbgState), 128'(DONE));
    chk("vs_rdata", rdataM, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    idleInputs();
    cyc();

    // Vector load at 0x300 with three wait cycles on beat 1
    memtoregM = 1'b1; memdataM = 1'b1; addrM = 32'h300;
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'h1111_1111;
    cyc();
    stallCnt = 0;
    chk("vl_b0_addr", 128'(memBus.mem_addr), 128'(32'h300));
    stallCnt += int'(stallM);
    cyc();
    memBus.mem_ack = 1'b0; memBus.mem_rdata = 32'hBAD0_BAD0;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("vl_wait_addr",  128'(memBus.mem_addr), 128'(32'h304));
      chk("vl_wait_stall", 128'(stallM), 128'(1));
      stallCnt += int'(stallM);
      cyc();
    end
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'h2222_2222;
    #1;
    chk("vl_b1_addr", 128'(memBus.mem_addr), 128'(32'h304));
    stallCnt += int'(stallM);
    cyc();
    memBus.mem_rdata = 32'h3333_3333;
    chk("vl_b2_addr", 128'(memBus.mem_addr), 128'(32'h308));
    stallCnt += int'(stallM);
    cyc();
    memBus.mem_rdata = 32'h4444_4444;
    chk("vl_b3_addr", 128'(memBus.mem_addr), 128'(32'h30C));
    stallCnt += int'(stallM);
    cyc();
    chk("vl_done",     128'(dbgState), 128'(DONE));
    chk("vl_stallcnt", 128'(stallCnt), 128'(7));
    chk("vl_rdata",    rdataM, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    idleInputs();
    cyc();

    // Scalar load touches lane 0 only
    memtoregM = 1'b1; addrM = 32'h600;
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'h9999_9999;
    cyc();
    cyc();
    chk("sl0_rdata", rdataM, 128'h4444_4444_3333_3333_2222_2222_9999_9999);
    idleInputs();
    cyc();

    // Vector load wrapping past the top of the address space
    memtoregM = 1'b1; memdataM = 1'b1; addrM = 32'hFFFF_FFF8;
    memBus.mem_ack = 1'b1;
    cyc();
    for (int b = 0; b < 4; b++) begin
      memBus.mem_rdata = 32'h5000_0000 + b;
      chk("wrap_addr", 128'(memBus.mem_addr), 128'(wrapAddr[b]));
      cyc();
    end
    chk("wrap_rdata", rdataM, 128'h5000_0003_5000_0002_5000_0001_5000_0000);
    idleInputs();
    cyc();

    // Combined load+store request: one write beat, load data untouched
    memtoregM = 1'b1; memwriteM = 1'b1; addrM = 32'h500;
    wdataM = {96'h0, 32'hCAFE_F00D};
    memBus.mem_ack = 1'b1; memBus.mem_rdata = 32'h1234_5678;
    cyc();
    chk("rw_we",    128'(memBus.mem_we), 128'(1));
    chk("rw_addr",  128'(memBus.mem_addr), 128'(32'h500));
    chk("rw_wdata", 128'(memBus.mem_wdata), 128'(32'hCAFE_F00D));
    cyc();
    chk("rw_done",  128'(dbgState), 128'(DONE));
    chk("rw_rdata", rdataM, 128'h5000_0003_5000_0002_5000_0001_5000_0000);
    idleInputs();
    cyc();

    // Reset during beat 2 of a vector load, with mem_ack high in the same cycle
    memtoregM = 1'b1; memdataM = 1'b1; addrM = 32'h400;
    memBus.mem_ack = 1'b1;
    cyc();
    memBus.mem_rdata = 32'hA0;
    cyc();
    memBus.mem_rdata = 32'hA1;
    cyc();
    memBus.mem_rdata = 32'hA2;
    chk("rm_b2_addr", 128'(memBus.mem_addr), 128'(32'h408));
    reset = 1'b1;
    cyc();
    chk("rm_state", 128'(dbgState), 128'(IDLE));
    chk("rm_req",   128'(memBus.mem_req), 128'(0));
    chk("rm_stall", 128'(stallM), 128'(0));
    chk("rm_rdata", rdataM, 128'(0));
    reset = 1'b0;
    idleInputs();
    cyc();
    chk("rm_after_req", 128'(memBus.mem_req), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
